counter: RTL and testbench
==========================

Name: counter

Overview:
- 4-bit multi-mode up/down counter for a simple score game.
- Supports a synchronous preload and four count modes selected by CONTROL.
- Tallies "winner" events (count reaches all-ones) and "loser" events (count reaches all-zeros).
- Declares GAMEOVER, with the winning side in WHO, when either tally reaches the limit. Stand-alone leaf block, single clock domain.

Parameters:
- WIDTH, 4, width of count, load and both tallies.
- LIMIT, 15, tally value that ends the game; must be ≤ 2^WIDTH-1.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- INIT  input  1  synchronous load request; when 1, count takes load.
- CONTROL  input  2  mode: 00 = +1, 01 = +2, 10 = −1, 11 = −2.
- WHO  output  2  game result: 00 = none, 10 = winner side won, 01 = loser side won.
- LOSER  output  1  registered 1-cycle flag: count just became 0.
- WINNER  output  1  registered 1-cycle flag: count just became 2^WIDTH-1.
- GAMEOVER  output  1  registered 1-cycle flag: a tally just reached LIMIT.
- load  input  WIDTH  preload value.
- count  output  WIDTH  counter value.
- count_loser  output  WIDTH  number of LOSER events since the last reset or game over.
- count_winner  output  WIDTH  number of WINNER events since the last reset or game over.

Behaviour:
- Reset (RST=0, asynchronous): count=0, count_winner=0, count_loser=0, WINNER=0, LOSER=0, GAMEOVER=0, WHO=00. Reset does not generate a LOSER event.
- Every rising edge with RST=1:
  - INIT=1: next = load. INIT has priority over CONTROL.
  - INIT=0: next = count ± 1 or 2 according to CONTROL, modulo 2^WIDTH.
  - Wrap examples: 15+1=0, 14+2=0, 15+2=1, 0−1=15, 1−2=15.
  - count <= next.
- Event flags:
  - WINNER <= (next == all-ones); LOSER <= (next == 0). Both flags are registered together with count, so each is high exactly in the cycle count shows that value.
  - Loads of 0 or all-ones also raise the corresponding flag.
  - Passing over a value without landing on it (e.g., 14+2) raises no flag.
- Tallies, on the same edge as the flag:
  - If next == all-ones, count_winner increments; if next == 0, count_loser increments.
  - Both conditions cannot occur in the same cycle.
- Game over:
  - On the edge where a tally becomes LIMIT, GAMEOVER <= 1 for one cycle.
  - On that edge WHO <= 10 (winner tally) or 01 (loser tally), and the tally shows LIMIT.
  - On the following edge both tallies clear to 0. Any event on that clearing edge is counted from 0, i.e., the tally becomes 1.
  - GAMEOVER then returns to 0. WHO holds until the next game over or reset.
  - count keeps running; the game restarts automatically.
- Asynchronous reset mid-game clears everything immediately, including WHO.

Test Plan:
- Reset: assert RST=0 with a running count -> all outputs 0 immediately; no LOSER pulse on release.
- Modes: INIT load=5, then CONTROL 00/01/10/11 one cycle each -> count 6, 8, 7, 5.
- Wrap and flags: load=13, CONTROL=01 -> 15 (WINNER=1, count_winner=1); CONTROL=00 -> 0 (LOSER=1, count_loser=1); CONTROL=11 from 1 -> 15 (WINNER).
- Skip: load=14, CONTROL=01 -> count=0 with LOSER; load=13, CONTROL=01 twice -> 15 (WINNER) then 1 (no flag).
- Winner game over: load=13, CONTROL=01 to 15, then repeat {+2 ×7 from 0 to 14, +1 ×2} 14 times -> count_winner hits 15 before count_loser (14). GAMEOVER pulses one cycle, WHO=10, tallies clear next edge, count continues.
- Loser game over: repeatedly land on 0 using CONTROL=10/11 with no all-ones landings -> at the 15th LOSER, GAMEOVER=1 and WHO=01. An INIT load of 3 afterwards loads count=3 with no flags.

Source files
------------

// File: rtl/counter.sv
// 4-bit multi-mode up/down score counter. It tallies landings on all-ones (winner)
// and on zero (loser), and declares game over when either tally reaches LIMIT.
module counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INIT,
  input  logic [1:0]       CONTROL,
  input  logic [WIDTH-1:0] load,
  output logic [1:0]       WHO,
  output logic             LOSER,
  output logic             WINNER,
  output logic             GAMEOVER,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_loser,
  output logic [WIDTH-1:0] count_winner
);

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_count_winner;
  logic [WIDTH-1:0] r_count_loser;
  logic             r_winner;
  logic             r_loser;
  logic             r_gameover;
  who_e             r_who;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_hit_ones;
  logic             w_hit_zero;
  logic [WIDTH-1:0] w_base_winner;
  logic [WIDTH-1:0] w_base_loser;
  logic [WIDTH-1:0] w_tally_winner;
  logic [WIDTH-1:0] w_tally_loser;
  logic             w_win;
  logic             w_lose;

  // CONTROL[0] picks the step size, CONTROL[1] the direction; arithmetic wraps.
  assign w_step = CONTROL[0] ? WIDTH'(2) : WIDTH'(1);
  assign w_next = INIT       ? load
                : CONTROL[1] ? r_count - w_step
                :              r_count + w_step;

  assign w_hit_ones = (w_next == ALL_ONES);
  assign w_hit_zero = (w_next == '0);

  // The cycle after game over the tallies restart from zero, so an event on that
  // same edge is counted into the fresh tally rather than lost.
  assign w_base_winner  = r_gameover ? '0 : r_count_winner;
  assign w_base_loser   = r_gameover ? '0 : r_count_loser;
  assign w_tally_winner = w_base_winner + {{(WIDTH-1){1'b0}}, w_hit_ones};
  assign w_tally_loser  = w_base_loser  + {{(WIDTH-1){1'b0}}, w_hit_zero};

  assign w_win  = w_hit_ones && (w_tally_winner == LIMIT_V);
  assign w_lose = w_hit_zero && (w_tally_loser  == LIMIT_V);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count        <= '0;
      r_count_winner <= '0;
      r_count_loser  <= '0;
      r_winner       <= 1'b0;
      r_loser        <= 1'b0;
      r_gameover     <= 1'b0;
      r_who          <= WHO_NONE;
    end else begin
      r_count        <= w_next;
      r_winner       <= w_hit_ones;
      r_loser        <= w_hit_zero;
      r_count_winner <= w_tally_winner;
      r_count_loser  <= w_tally_loser;
      r_gameover     <= w_win || w_lose;
      if (w_win) begin
        r_who <= WHO_WINNER;
      end else if (w_lose) begin
        r_who <= WHO_LOSER;
      end
    end
  end

  assign count        = r_count;
  assign count_winner = r_count_winner;
  assign count_loser  = r_count_loser;
  assign WINNER       = r_winner;
  assign LOSER        = r_loser;
  assign GAMEOVER     = r_gameover;
  assign WHO          = r_who;

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for the score counter: reset, count modes, wrap,
// skip-over, and both game-over directions with hand-computed expectations.
module tb_counter;

  logic       CLK;
  logic       RST;
  logic       INIT;
  logic [1:0] CONTROL;
  logic [3:0] load;
  logic [1:0] WHO;
  logic       LOSER;
  logic       WINNER;
  logic       GAMEOVER;
  logic [3:0] count;
  logic [3:0] count_loser;
  logic [3:0] count_winner;

  int checks   = 0;
  int failures = 0;

  counter #(.WIDTH(4), .LIMIT(15)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .INIT         (INIT),
    .CONTROL      (CONTROL),
    .load         (load),
    .WHO          (WHO),
    .LOSER        (LOSER),
    .WINNER       (WINNER),
    .GAMEOVER     (GAMEOVER),
    .count        (count),
    .count_loser  (count_loser),
    .count_winner (count_winner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; INIT = 1'b0; CONTROL = 2'b00; load = 4'd0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({WINNER, LOSER, GAMEOVER} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {WINNER, LOSER, GAMEOVER}); end
    checks++; if ({count_winner, count_loser, WHO} !== 10'd0) begin failures++; $display("FAIL reset_tallies: got w=%0d l=%0d who=%b want 0 0 00", count_winner, count_loser, WHO); end
    // 0 - 1 wraps to all-ones
    CONTROL = 2'b10; step();
    checks++; if ({count, WINNER, LOSER, count_winner} !== {4'd15, 1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL reset_wrap_down: got c=%0d W=%b L=%b cw=%0d want 15 1 0 1", count, WINNER, LOSER, count_winner); end
    CONTROL = 2'b00; step(); step();
    checks++; if ({count, count_loser} !== {4'd1, 4'd1}) begin failures++; $display("FAIL reset_prerun: got c=%0d cl=%0d want 1 1", count, count_loser); end
    #2; RST = 1'b0; #1;
    checks++; if ({count, count_winner, count_loser} !== 12'd0) begin failures++; $display("FAIL reset_async: got c=%0d cw=%0d cl=%0d want 0 0 0", count, count_winner, count_loser); end
    checks++; if ({WINNER, LOSER, GAMEOVER, WHO} !== 5'd0) begin failures++; $display("FAIL reset_async_flags: got %b want 00000", {WINNER, LOSER, GAMEOVER, WHO}); end
    @(negedge CLK); RST = 1'b1; #1;
    checks++; if (LOSER !== 1'b0) begin failures++; $display("FAIL reset_release_loser: got %b want 0", LOSER); end
    step();
    checks++; if ({count, LOSER, count_loser} !== {4'd1, 1'b0, 4'd0}) begin failures++; $display("FAIL reset_after_release: got c=%0d L=%b cl=%0d want 1 0 0", count, LOSER, count_loser); end
  endtask

  task automatic test_modes();
    do_reset();
    INIT = 1'b1; load = 4'd5; step();
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL modes_load: got %0d want 5", count); end
    INIT = 1'b0;
    CONTROL = 2'b00; step();
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL modes_inc1: got %0d want 6", count); end
    CONTROL = 2'b01; step();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL modes_inc2: got %0d want 8", count); end
    CONTROL = 2'b10; step();
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL modes_dec1: got %0d want 7", count); end
    CONTROL = 2'b11; step();
    checks++; if ({count, WINNER, LOSER} !== {4'd5, 2'b00}) begin failures++; $display("FAIL modes_dec2: got c=%0d W=%b L=%b want 5 0 0", count, WINNER, LOSER); end
    // INIT has priority over CONTROL
    INIT = 1'b1; load = 4'd9; CONTROL = 2'b01; step();
    checks++; if (count !== 4'd9) begin failures++; $display("FAIL modes_init_prio: got %0d want 9", count); end
    INIT = 1'b0;
  endtask

  task automatic test_wrap_flags();
    do_reset();
    INIT = 1'b1; load = 4'd13; step();
    INIT = 1'b0; CONTROL = 2'b01; step();
    checks++; if ({count, WINNER, count_winner} !== {4'd15, 1'b1, 4'd1}) begin failures++; $display("FAIL wrap_to_ones: got c=%0d W=%b cw=%0d want 15 1 1", count, WINNER, count_winner); end
    CONTROL = 2'b00; step();
    checks++; if ({count, LOSER, WINNER, count_loser} !== {4'd0, 1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL wrap_to_zero: got c=%0d L=%b W=%b cl=%0d want 0 1 0 1", count, LOSER, WINNER, count_loser); end
    step();
    checks++; if ({count, LOSER, WINNER} !== {4'd1, 2'b00}) begin failures++; $display("FAIL wrap_flag_drop: got c=%0d L=%b W=%b want 1 0 0", count, LOSER, WINNER); end
    CONTROL = 2'b11; step();
    checks++; if ({count, WINNER, count_winner} !== {4'd15, 1'b1, 4'd2}) begin failures++; $display("FAIL wrap_1_minus_2: got c=%0d W=%b cw=%0d want 15 1 2", count, WINNER, count_winner); end
  endtask

  task automatic test_skip();
    do_reset();
    INIT = 1'b1; load = 4'd14; step();
    INIT = 1'b0; CONTROL = 2'b01; step();
    checks++; if ({count, LOSER, WINNER, count_loser} !== {4'd0, 1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL skip_14p2: got c=%0d L=%b W=%b cl=%0d want 0 1 0 1", count, LOSER, WINNER, count_loser); end
    INIT = 1'b1; load = 4'd13; step();
    INIT = 1'b0; step();
    checks++; if ({count, WINNER, count_winner} !== {4'd15, 1'b1, 4'd1}) begin failures++; $display("FAIL skip_13p2: got c=%0d W=%b cw=%0d want 15 1 1", count, WINNER, count_winner); end
    step();
    checks++; if ({count, WINNER, LOSER, count_winner, count_loser} !== {4'd1, 2'b00, 4'd1, 4'd1}) begin failures++; $display("FAIL skip_15p2: got c=%0d W=%b L=%b cw=%0d cl=%0d want 1 0 0 1 1", count, WINNER, LOSER, count_winner, count_loser); end
    // loads of the extremes raise flags too
    INIT = 1'b1; load = 4'd0; step();
    checks++; if ({LOSER, count_loser} !== {1'b1, 4'd2}) begin failures++; $display("FAIL skip_load_zero: got L=%b cl=%0d want 1 2", LOSER, count_loser); end
    INIT = 1'b0;
  endtask

  task automatic test_winner_gameover();
    do_reset();
    INIT = 1'b1; load = 4'd13; step();
    INIT = 1'b0; CONTROL = 2'b01; step();
    // each round: land on 0 (loser), climb by 2 to 14, +1 onto 15 (winner)
    for (int k = 1; k <= 14; k++) begin
      CONTROL = 2'b00; step();
      checks++; if ({count, LOSER, count_loser} !== {4'd0, 1'b1, 4'(k)}) begin failures++; $display("FAIL win_round%0d_zero: got c=%0d L=%b cl=%0d want 0 1 %0d", k, count, LOSER, count_loser, k); end
      CONTROL = 2'b01;
      for (int j = 0; j < 7; j++) step();
      CONTROL = 2'b00; step();
      checks++; if ({count, WINNER, count_winner} !== {4'd15, 1'b1, 4'(k + 1)}) begin failures++; $display("FAIL win_round%0d_ones: got c=%0d W=%b cw=%0d want 15 1 %0d", k, count, WINNER, count_winner, k + 1); end
      checks++; if ({GAMEOVER, WHO} !== ((k == 14) ? 3'b110 : 3'b000)) begin failures++; $display("FAIL win_round%0d_gameover: got GO=%b WHO=%b want %b", k, GAMEOVER, WHO, (k == 14) ? 3'b110 : 3'b000); end
    end
    checks++; if (count_loser !== 4'd14) begin failures++; $display("FAIL win_loser_tally: got %0d want 14", count_loser); end
    // clearing edge: the loser landing here restarts from zero
    step();
    checks++; if ({count, LOSER, count_loser, count_winner} !== {4'd0, 1'b1, 4'd1, 4'd0}) begin failures++; $display("FAIL win_clear: got c=%0d L=%b cl=%0d cw=%0d want 0 1 1 0", count, LOSER, count_loser, count_winner); end
    checks++; if ({GAMEOVER, WHO} !== 3'b010) begin failures++; $display("FAIL win_who_hold: got GO=%b WHO=%b want 0 10", GAMEOVER, WHO); end
    CONTROL = 2'b01; step();
    checks++; if ({count, count_loser, WHO} !== {4'd2, 4'd1, 2'b10}) begin failures++; $display("FAIL win_continue: got c=%0d cl=%0d WHO=%b want 2 1 10", count, count_loser, WHO); end
  endtask

  task automatic test_loser_gameover();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      INIT = 1'b1; load = (i % 2 == 1) ? 4'd2 : 4'd1; step();
      checks++; if ({count, LOSER, WINNER} !== {load, 2'b00}) begin failures++; $display("FAIL lose_round%0d_load: got c=%0d L=%b W=%b want %0d 0 0", i, count, LOSER, WINNER, load); end
      INIT = 1'b0; CONTROL = (i % 2 == 1) ? 2'b11 : 2'b10; step();
      checks++; if ({count, LOSER, count_loser, count_winner} !== {4'd0, 1'b1, 4'(i), 4'd0}) begin failures++; $display("FAIL lose_round%0d_zero: got c=%0d L=%b cl=%0d cw=%0d want 0 1 %0d 0", i, count, LOSER, count_loser, count_winner, i); end
      checks++; if ({GAMEOVER, WHO} !== ((i == 15) ? 3'b101 : 3'b000)) begin failures++; $display("FAIL lose_round%0d_gameover: got GO=%b WHO=%b want %b", i, GAMEOVER, WHO, (i == 15) ? 3'b101 : 3'b000); end
    end
    INIT = 1'b1; load = 4'd3; step();
    checks++; if ({count, LOSER, WINNER, GAMEOVER} !== {4'd3, 3'b000}) begin failures++; $display("FAIL lose_load3: got c=%0d L=%b W=%b GO=%b want 3 0 0 0", count, LOSER, WINNER, GAMEOVER); end
    checks++; if ({count_loser, count_winner, WHO} !== {4'd0, 4'd0, 2'b01}) begin failures++; $display("FAIL lose_cleared: got cl=%0d cw=%0d WHO=%b want 0 0 01", count_loser, count_winner, WHO); end
    INIT = 1'b0;
    #2; RST = 1'b0; #1;
    checks++; if ({WHO, count} !== {2'b00, 4'd0}) begin failures++; $display("FAIL lose_reset_who: got WHO=%b c=%0d want 00 0", WHO, count); end
    @(negedge CLK); RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; INIT = 1'b0; CONTROL = 2'b00; load = 4'd0;
    test_reset();
    test_modes();
    test_wrap_flags();
    test_skip();
    test_winner_gameover();
    test_loser_gameover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
